// File: rtl/tone_sequencer.sv
// tone_sequencer: steps an 8-note tone_div ROM and applies an attack/sustain/release envelope to the PCM stream.
// Optional macro TONE_SEQ_REST_EN inserts REST_STEPS silent envelope steps between notes.
module tone_sequencer #(
    parameter int DIV_W         = 8,
    parameter int ENV_STEP_CYC  = 256,
    parameter int SUSTAIN_STEPS = 32,
    parameter int REST_STEPS    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic [11:0]      pcm_in,
    output logic [11:0]      pcm_out,
    output logic [DIV_W-1:0] tone_div,
    output logic [2:0]       note_idx,
    output logic             busy,
    output logic             done
);
    localparam int SW = $clog2(ENV_STEP_CYC);
    localparam int UW = $clog2(SUSTAIN_STEPS + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(ENV_STEP_CYC - 1);
    localparam logic [UW-1:0] SUS_LAST = UW'(SUSTAIN_STEPS - 1);
    localparam logic [11:0] MID = 12'd2048;
    localparam logic [7:0] ROM [8] = '{8'd60, 8'd53, 8'd47, 8'd45, 8'd40, 8'd35, 8'd31, 8'd30};

    typedef enum logic [2:0] {
        IDLE, ATTACK, SUSTAIN, RELEASE, NEXT
`ifdef TONE_SEQ_REST_EN
        , REST
`endif
    } state_t;

    state_t state;
    logic [SW-1:0] step_cnt;
    logic [UW-1:0] sus_cnt;
    logic [4:0] env;
    logic stop_pending;
    logic strobe;
    logic signed [12:0] s;
    logic signed [18:0] p;
    logic signed [18:0] r;
    logic [11:0] gain_out;
`ifdef TONE_SEQ_REST_EN
    localparam int RW = $clog2(REST_STEPS + 1);
    localparam logic [RW-1:0] REST_LAST = RW'(REST_STEPS - 1);
    logic [RW-1:0] rest_cnt;
`endif

    assign strobe = step_cnt == STEP_LAST;
    assign s = $signed({1'b0, pcm_in}) - 13'sd2048;
    assign p = 19'(s) * 19'($signed({1'b0, env}));
    assign r = (p >>> 4) + 19'sd2048;
    assign gain_out = r[18] ? 12'd0 : (r > 19'sd4095) ? 12'd4095 : r[11:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            step_cnt     <= '0;
            sus_cnt      <= '0;
            env          <= '0;
            stop_pending <= 1'b0;
            note_idx     <= '0;
            tone_div     <= DIV_W'(ROM[0]);
            pcm_out      <= MID;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef TONE_SEQ_REST_EN
            rest_cnt     <= '0;
`endif
        end else begin
            done     <= 1'b0;
            pcm_out  <= (state == IDLE) ? MID : gain_out;
            // step timing restarts with every note so each note has the same length
            step_cnt <= (state == IDLE || state == NEXT || strobe) ? '0 : step_cnt + 1'b1;
            if (stop && state != IDLE) stop_pending <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    state        <= ATTACK;
                    busy         <= 1'b1;
                    note_idx     <= '0;
                    tone_div     <= DIV_W'(ROM[0]);
                    env          <= '0;
                    stop_pending <= 1'b0;
                end
                ATTACK: if (stop || stop_pending) state <= RELEASE;
                else if (strobe) begin
                    env <= env + 1'b1;
                    if (env == 5'd15) begin
                        state   <= SUSTAIN;
                        sus_cnt <= '0;
                    end
                end
                SUSTAIN: if (stop || stop_pending) state <= RELEASE;
                else if (strobe) begin
                    sus_cnt <= sus_cnt + 1'b1;
                    if (sus_cnt == SUS_LAST) state <= RELEASE;
                end
                RELEASE: if (env == '0) state <= NEXT;
                else if (strobe) begin
                    env <= env - 1'b1;
                    if (env == 5'd1) state <= NEXT;
                end
                NEXT: if (stop_pending || (note_idx == 3'd7 && !loop)) begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    note_idx     <= '0;
                    tone_div     <= DIV_W'(ROM[0]);
                    stop_pending <= 1'b0;
                end else begin
                    note_idx <= note_idx + 3'd1;
                    tone_div <= DIV_W'(ROM[note_idx + 3'd1]);
`ifdef TONE_SEQ_REST_EN
                    state    <= REST;
                    rest_cnt <= '0;
`else
                    state    <= ATTACK;
`endif
                end
`ifdef TONE_SEQ_REST_EN
                REST: if (stop || stop_pending) begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    note_idx     <= '0;
                    tone_div     <= DIV_W'(ROM[0]);
                    stop_pending <= 1'b0;
                end else if (strobe) begin
                    rest_cnt <= rest_cnt + 1'b1;
                    if (rest_cnt == REST_LAST) state <= ATTACK;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: scoreboard bench; stimulus queues expected samples/events, a negedge monitor pops and compares.
module tb_tone_sequencer;
`ifdef TONE_SEQ_REST_EN
    localparam int R = 8;
`else
    localparam int R = 0;
`endif
    localparam int P = 161 + R;
    localparam logic [7:0] ROM [8] = '{8'd60, 8'd53, 8'd47, 8'd45, 8'd40, 8'd35, 8'd31, 8'd30};

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [11:0] pcm_in = 12'd4000;
    logic [11:0] pcm_out;
    logic [7:0] tone_div;
    logic [2:0] note_idx;
    logic busy, done;

    tone_sequencer #(.DIV_W(8), .ENV_STEP_CYC(4), .SUSTAIN_STEPS(8), .REST_STEPS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop), .pcm_in(pcm_in),
        .pcm_out(pcm_out), .tone_div(tone_div), .note_idx(note_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; logic [11:0] pcm; logic [7:0] td; logic b;} samp_t;
    typedef struct {int c; logic is_done; logic [2:0] note; logic [7:0] td;} evt_t;
    samp_t sq[$];
    evt_t eq[$];
    int checks = 0, failures = 0;
    logic [2:0] prev_note = 3'd0;
    samp_t sm;

    function automatic void exp_samp(input int c, input logic [11:0] pcm, input logic [7:0] td, input logic b);
        sq.push_back('{c, pcm, td, b});
    endfunction

    function automatic void exp_note(input int c, input logic [2:0] n);
        eq.push_back('{c, 1'b0, n, ROM[n]});
    endfunction

    function automatic void exp_done(input int c);
        exp_note(c, 3'd0);
        eq.push_back('{c, 1'b1, 3'd0, 8'd60});
    endfunction

    task automatic got_event(input logic is_done);
        evt_t e;
        checks++;
        if (eq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s cyc=%0d note_idx=%0d", is_done ? "done" : "note", cyc, note_idx);
            return;
        end
        e = eq.pop_front();
        if (e.is_done != is_done || e.c != cyc || (!is_done && (e.note != note_idx || e.td != tone_div))) begin
            failures++;
            $display("FAIL event: got done=%0b note=%0d tone_div=%0d at cyc %0d, expected done=%0b note=%0d tone_div=%0d at cyc %0d",
                     is_done, note_idx, tone_div, cyc, e.is_done, e.note, e.td, e.c);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (sq.size() > 0 && sq[0].c <= cyc) begin
                sm = sq.pop_front();
                checks++;
                if (sm.c != cyc || pcm_out !== sm.pcm || tone_div !== sm.td || busy !== sm.b) begin
                    failures++;
                    $display("FAIL sample@%0d: pcm_out=%0d tone_div=%0d busy=%0b at cyc %0d, expected %0d %0d %0b",
                             sm.c, pcm_out, tone_div, busy, cyc, sm.pcm, sm.td, sm.b);
                end
            end
            if (note_idx !== prev_note) got_event(1'b0);
            if (done === 1'b1) got_event(1'b1);
            prev_note = note_idx;
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start(input int k, input logic with_stop);
        wait_cyc(k - 1);
        start = 1'b1;
        stop = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic pulse_stop(input int k);
        wait_cyc(k - 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int e, a;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_samp(cyc + 2, 12'd2048, 8'd60, 1'b0);
        wait_cyc(cyc + 3);

        // one-shot playback of all 8 notes, with gain points at env=8
        pcm_in = 12'd3072;
        e = cyc + 2;
        for (int n = 1; n < 8; n++) exp_note(e + P * n - R, 3'(n));
        exp_done(e + 8 * P - R);
        exp_samp(e, 12'd2048, 8'd60, 1'b1);
        exp_samp(e + 33, 12'd1024, 8'd60, 1'b1);
        exp_samp(e + 34, 12'd3071, 8'd60, 1'b1);
        exp_samp(e + 35, 12'd2048, 8'd60, 1'b1);
        exp_samp(e + 64, 12'd3008, 8'd60, 1'b1);
        exp_samp(e + 65, 12'd3072, 8'd60, 1'b1);
        if (R != 0) exp_samp(e + 165, 12'd2048, 8'd53, 1'b1);
        exp_samp(e + 8 * P - R + 2, 12'd2048, 8'd60, 1'b0);
        pulse_start(e, 1'b0);
        wait_cyc(e + 32); pcm_in = 12'd0;
        wait_cyc(e + 33); pcm_in = 12'd4095;
        wait_cyc(e + 34); pcm_in = 12'd2048;
        wait_cyc(e + 35); pcm_in = 12'd3072;
        wait_cyc(e + 8 * P - R + 4);

        // stop during sustain of note 2
        e = cyc + 2;
        a = e + 2 * P;
        exp_note(e + P - R, 3'd1);
        exp_note(e + 2 * P - R, 3'd2);
        exp_samp(a + 109, 12'd2560, 8'd47, 1'b1);
        exp_done(a + 141);
        exp_samp(a + 143, 12'd2048, 8'd60, 1'b0);
        pulse_start(e, 1'b0);
        pulse_stop(a + 78);
        wait_cyc(a + 146);

        // start+stop together, looped playback, start while busy, stop in attack
        loop = 1'b1;
        e = cyc + 2;
        a = e + 9 * P;
        for (int n = 1; n < 8; n++) exp_note(e + P * n - R, 3'(n));
        exp_note(e + 8 * P - R, 3'd0);
        exp_samp(e + 8 * P - R + 2, 12'd2048, 8'd60, 1'b1);
        exp_note(e + 9 * P - R, 3'd1);
        exp_done(a + 17);
        exp_samp(a + 19, 12'd2048, 8'd60, 1'b0);
        pulse_start(e, 1'b1);
        pulse_start(e + 200, 1'b0);
        wait_cyc(e + 8 * P);
        loop = 1'b0;
        pulse_stop(a + 11);
        wait_cyc(a + 22);

`ifdef TONE_SEQ_REST_EN
        // stop during rest
        e = cyc + 2;
        exp_note(e + 161, 3'd1);
        exp_done(e + 163);
        exp_samp(e + 165, 12'd2048, 8'd60, 1'b0);
        pulse_start(e, 1'b0);
        pulse_stop(e + 163);
        wait_cyc(e + 168);
`endif

        repeat (4) @(negedge clk);
        checks++;
        if (eq.size() != 0 || sq.size() != 0) begin
            failures++;
            $display("FAIL leftover: events=%0d samples=%0d still pending, expected 0 0", eq.size(), sq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Controller for the audio chain: sine generator → tone_sequencer → PWM DAC.
- Steps through a fixed 8-note table and drives the sine generator's programmable period (`tone_div`).
- Applies an attack/sustain/release amplitude envelope to the generator's 12-bit PCM before it reaches the DAC.
- Optional one-shot or looped playback; idle output is midscale silence.

Parameters:
- DIV_W, 8, width of `tone_div` (sine generator step delay; larger = lower pitch)
- ENV_STEP_CYC, 256, clk cycles per envelope step (≥2)
- SUSTAIN_STEPS, 32, envelope steps held at full gain per note (≥1)
- REST_STEPS, 8, silent steps between notes (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins playback at note 0
- stop  in  1  single-cycle pulse; graceful stop via release
- loop  in  1  level; sampled at end of last note: 1 = wrap to note 0, 0 = finish
- pcm_in  in  12  unsigned offset-binary sample from sine generator, midscale 2048
- pcm_out  out  12  enveloped sample to PWM DAC
- tone_div  out  DIV_W  period setting for sine generator
- note_idx  out  3  current note index
- busy  out  1  high in any state except IDLE
- done  out  1  single-cycle pulse on return to IDLE

Behaviour:
- Reset values: state=IDLE, env=0, step_cnt=0, note_idx=0, pcm_out=2048, tone_div=ROM[0], busy=0, done=0.
- Note ROM (`tone_div` values, index 0..7): 60, 53, 47, 45, 40, 35, 31, 30.
  - `tone_div` = ROM[note_idx], registered, updated the cycle `note_idx` changes.
- Step strobe:
  - `step_cnt` counts 0..ENV_STEP_CYC-1 and wraps; strobe fires when `step_cnt`=ENV_STEP_CYC-1.
  - `step_cnt` is cleared on start.
- Envelope `env` is 5 bits, range 0..16.
- States:
  - IDLE: start → ATTACK, with note_idx=0, env=0, step_cnt=0. stop is ignored. start+stop in the same cycle: start wins.
  - ATTACK: env+1 per strobe. On the strobe where env becomes 16 → SUSTAIN, with sus_cnt=0.
  - SUSTAIN: sus_cnt+1 per strobe. On the strobe where sus_cnt=SUSTAIN_STEPS-1 → RELEASE.
  - RELEASE: env-1 per strobe. On the strobe where env becomes 0 → NEXT.
  - NEXT (1 cycle):
    - if stop_pending → IDLE;
    - else if note_idx<7 → note_idx+1, go to ATTACK;
    - else if loop → note_idx=0, go to ATTACK;
    - else → IDLE.
    - done=1 in the same cycle the transition to IDLE is registered.
- stop while in ATTACK or SUSTAIN:
  - sets stop_pending; next cycle → RELEASE from the current env (no jump in env).
  - Ends in IDLE with done; note_idx is reset to 0 on entering IDLE.
- stop in RELEASE or NEXT: sets stop_pending only.
- start while busy: ignored.
- Gain:
  - s = pcm_in − 2048 (signed 13-bit); p = s·env (signed 18-bit).
  - pcm_out = 2048 + (p >>> 4), arithmetic shift, clamped to 0..4095.
  - env=16 is exact unity; env=0 gives 2048.
  - Registered: 1 clk latency from pcm_in.
  - In IDLE, pcm_out=2048 regardless of pcm_in.
- Per-note duration (no rest): (32+SUSTAIN_STEPS)·ENV_STEP_CYC + 1 cycles.
- Reset asserted mid-playback: immediate return to reset values, no done pulse.

Optional Feature:
- Macro: TONE_SEQ_REST_EN.
- Defined:
  - NEXT goes to a REST state instead of ATTACK.
  - REST holds env=0 for REST_STEPS strobes, then → ATTACK with the new note_idx.
  - stop during REST → IDLE on the next cycle, with done.
- Undefined: the REST state and its counter are not built; NEXT → ATTACK directly.

Test Plan:
All cases use ENV_STEP_CYC=4, SUSTAIN_STEPS=8, no TONE_SEQ_REST_EN unless noted.

- Reset, then pcm_in=4000 idle: pcm_out=2048, tone_div=60, busy=0, done=0.
- Pulse start, loop=0, pcm_in held 3072:
  - 64 cycles after start, env=16 and pcm_out=3072.
  - note_idx steps 0→7 every 161 cycles; tone_div follows the ROM.
  - done pulses exactly once after 8·161 cycles; then pcm_out=2048.
- Gain arithmetic at env=8: pcm_in=0 → pcm_out=1024; pcm_in=4095 → 3071; pcm_in=2048 → 2048.
- stop pulsed in SUSTAIN of note 2:
  - env ramps 16→0 over 64 cycles; no note 3;
  - done=1; note_idx returns 0.
  - start and stop together in IDLE → playback starts.
- loop=1, let note 7 finish: note_idx wraps to 0, busy stays 1, no done; a start pulse while busy is ignored.
- With TONE_SEQ_REST_EN, REST_STEPS=2:
  - 8 cycles of pcm_out=2048 between notes.
  - stop during REST → IDLE next cycle, with done.
